// File: rtl/rf_alu_pkg.sv
// Shared definitions for the RF/ALU sequencer: widths, opcodes, instruction
// field positions, flag bit indices, FSM encoding and the decode payload.
package rf_alu_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned OPW   = 4;
  localparam int unsigned IMM5W = 5;
  localparam int unsigned IMM9W = 9;
  localparam int unsigned FLAGW = 4;

  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_LSB = 9;
  localparam int unsigned RA_LSB = 6;
  localparam int unsigned RB_LSB = 3;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_ADC  = 4'h1;
  localparam logic [OPW-1:0] OP_SUB  = 4'h2;
  localparam logic [OPW-1:0] OP_SBB  = 4'h3;
  localparam logic [OPW-1:0] OP_ADDI = 4'h4;
  localparam logic [OPW-1:0] OP_SUBI = 4'h5;
  localparam logic [OPW-1:0] OP_LDI  = 4'h6;
  localparam logic [OPW-1:0] OP_MOV  = 4'h7;
  localparam logic [OPW-1:0] OP_NOP  = 4'hF;

  // Bit positions inside the {Z,N,C,V} flag register.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic adc;
    logic sub;
    logic sbb;
    logic src_b;
    logic uses_carry;
    logic writes_rd;
    logic sets_flags;
    logic is_ldi;
    logic zero_imm;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/rf_alu_decode.sv
// Combinational opcode decoder: ALU mode lines and sequencing attributes.
module rf_alu_decode
  import rf_alu_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  output dec_t           o_dec
);

  always_comb begin
    o_dec = '0;
    unique case (i_op)
      OP_ADD:  begin o_dec.writes_rd = 1'b1; o_dec.sets_flags = 1'b1; end
      OP_ADC:  begin o_dec.writes_rd = 1'b1; o_dec.sets_flags = 1'b1;
                     o_dec.adc = 1'b1; o_dec.uses_carry = 1'b1; end
      OP_SUB:  begin o_dec.writes_rd = 1'b1; o_dec.sets_flags = 1'b1;
                     o_dec.sub = 1'b1; end
      OP_SBB:  begin o_dec.writes_rd = 1'b1; o_dec.sets_flags = 1'b1;
                     o_dec.sbb = 1'b1; o_dec.uses_carry = 1'b1; end
      OP_ADDI: begin o_dec.writes_rd = 1'b1; o_dec.sets_flags = 1'b1;
                     o_dec.src_b = 1'b1; end
      OP_SUBI: begin o_dec.writes_rd = 1'b1; o_dec.sets_flags = 1'b1;
                     o_dec.src_b = 1'b1; o_dec.sub = 1'b1; end
      OP_LDI:  begin o_dec.writes_rd = 1'b1; o_dec.is_ldi = 1'b1; end
      // MOV rides the ADDI path with a forced zero immediate.
      OP_MOV:  begin o_dec.writes_rd = 1'b1; o_dec.src_b = 1'b1;
                     o_dec.zero_imm = 1'b1; end
      OP_NOP:  ;
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Control sequencer for the RF+ALU datapath: IDLE -> EXEC -> WB per instruction,
// architectural {Z,N,C,V} flag register and one-cycle writeback strobe.
module rf_alu_sequencer
  import rf_alu_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [DW-1:0]    instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [DW-1:0]    Y,
  input  logic             Z,
  input  logic             N,
  input  logic             C,
  input  logic             V,
  output logic [AW-1:0]    Read_Addr_A,
  output logic [AW-1:0]    Read_Addr_B,
  output logic [AW-1:0]    Write_Addr,
  output logic [DW-1:0]    Write_Data,
  output logic             Write_En,
  output logic             ADC,
  output logic             SUB,
  output logic             SBB,
  output logic             Pre_C,
  output logic             Src_ALU_B,
  output logic [IMM5W-1:0] imm5,
  output logic [FLAGW-1:0] flags,
  output logic             illegal
);

  state_t           r_state;
  logic [DW-1:0]    r_instr;
  logic             r_ready;
  logic [AW-1:0]    r_raddr_a;
  logic [AW-1:0]    r_raddr_b;
  logic [AW-1:0]    r_waddr;
  logic [DW-1:0]    r_wdata;
  logic             r_we;
  logic             r_adc;
  logic             r_sub;
  logic             r_sbb;
  logic             r_pre_c;
  logic             r_src_b;
  logic [IMM5W-1:0] r_imm5;
  logic [FLAGW-1:0] r_flags;
  logic             r_illegal;

  logic [OPW-1:0]   w_op;
  logic             w_fire;
  dec_t             w_dec;

  // Decode the incoming word while idle, the latched word otherwise.
  assign w_op   = (r_state == ST_IDLE) ? instr[OP_LSB +: OPW] : r_instr[OP_LSB +: OPW];
  assign w_fire = instr_valid & r_ready;

  rf_alu_decode u_decode (
    .i_op  (w_op),
    .o_dec (w_dec)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_IDLE;
      r_instr   <= '0;
      r_ready   <= 1'b1;
      r_raddr_a <= '0;
      r_raddr_b <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_adc     <= 1'b0;
      r_sub     <= 1'b0;
      r_sbb     <= 1'b0;
      r_pre_c   <= 1'b0;
      r_src_b   <= 1'b0;
      r_imm5    <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            if (w_dec.illegal) begin
              r_illegal <= 1'b1;
            end else if (w_dec.writes_rd) begin
              r_instr   <= instr;
              r_state   <= ST_EXEC;
              r_ready   <= 1'b0;
              r_raddr_a <= instr[RA_LSB +: AW];
              r_raddr_b <= instr[RB_LSB +: AW];
              r_imm5    <= w_dec.zero_imm ? IMM5W'(0) : instr[IMM5W-1:0];
              r_src_b   <= w_dec.src_b;
              r_adc     <= w_dec.adc;
              r_sub     <= w_dec.sub;
              r_sbb     <= w_dec.sbb;
              r_pre_c   <= w_dec.uses_carry & r_flags[FLAG_C];
            end
          end
        end
        ST_EXEC: begin
          r_wdata <= w_dec.is_ldi ? DW'(r_instr[IMM9W-1:0]) : Y;
          if (w_dec.sets_flags) begin
            r_flags[FLAG_Z] <= Z;
            r_flags[FLAG_N] <= N;
            r_flags[FLAG_C] <= C;
            r_flags[FLAG_V] <= V;
          end
          r_we    <= 1'b1;
          r_waddr <= r_instr[RD_LSB +: AW];
          r_adc   <= 1'b0;
          r_sub   <= 1'b0;
          r_sbb   <= 1'b0;
          r_pre_c <= 1'b0;
          r_src_b <= 1'b0;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobe is masked by clr so a reset landing on the WB edge cancels the write.
  assign Write_En    = r_we & ~clr;
  assign instr_ready = r_ready;
  assign Read_Addr_A = r_raddr_a;
  assign Read_Addr_B = r_raddr_b;
  assign Write_Addr  = r_waddr;
  assign Write_Data  = r_wdata;
  assign ADC         = r_adc;
  assign SUB         = r_sub;
  assign SBB         = r_sbb;
  assign Pre_C       = r_pre_c;
  assign Src_ALU_B   = r_src_b;
  assign imm5        = r_imm5;
  assign flags       = r_flags;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer with a behavioural register file + ALU.
module tb_rf_alu_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] Y;
  logic        Z, N, C, V;
  logic [2:0]  Read_Addr_A, Read_Addr_B, Write_Addr;
  logic [15:0] Write_Data;
  logic        Write_En;
  logic        ADC, SUB, SBB, Pre_C, Src_ALU_B;
  logic [4:0]  imm5;
  logic [3:0]  flags;
  logic        illegal;

  always #5 clk = ~clk;

  rf_alu_sequencer dut (
    .clk(clk), .clr(clr), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Y(Y), .Z(Z), .N(N), .C(C), .V(V),
    .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B),
    .Write_Addr(Write_Addr), .Write_Data(Write_Data), .Write_En(Write_En),
    .ADC(ADC), .SUB(SUB), .SBB(SBB), .Pre_C(Pre_C), .Src_ALU_B(Src_ALU_B),
    .imm5(imm5), .flags(flags), .illegal(illegal)
  );

  // Datapath model: register file plus adder with optional forced result.
  logic [15:0] rf [8];
  int          we_count;
  logic        frc;
  logic [15:0] fy;
  logic [3:0]  ff;

  always @(posedge clk) begin
    if (Write_En) begin
      rf[Write_Addr] <= Write_Data;
      we_count <= we_count + 1;
    end
  end

  logic [15:0] a_v, b_v, beff;
  logic        cin;
  logic [16:0] sum;
  always_comb begin
    a_v  = rf[Read_Addr_A];
    b_v  = Src_ALU_B ? {11'b0, imm5} : rf[Read_Addr_B];
    beff = (SUB | SBB) ? ~b_v : b_v;
    cin  = SUB ? 1'b1 : ((ADC | SBB) ? Pre_C : 1'b0);
    sum  = {1'b0, a_v} + {1'b0, beff} + {16'b0, cin};
    Y = sum[15:0];
    Z = (sum[15:0] == 16'h0000);
    N = sum[15];
    C = sum[16];
    V = (a_v[15] == beff[15]) && (sum[15] != a_v[15]);
    if (frc) begin
      Y = fy;
      {Z, N, C, V} = ff;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic        frc;
    logic [15:0] fy;
    logic [3:0]  ff;
    logic [4:0]  mode;   // {ADC,SUB,SBB,Pre_C,Src_ALU_B} during EXEC
    logic [4:0]  imm;    // checked only when Src_ALU_B expected
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [3:0]  fl;     // {Z,N,C,V} after writeback
  } vec_t;

  vec_t vecs[11];

  task automatic wait_ready(input string nm);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) chk({nm, "_ready_timeout"}, 32'(instr_ready), 32'd1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int wc0;
    string p;
    p = $sformatf("v%0d", i);
    wait_ready(p);
    wc0 = we_count;
    instr = v.instr; instr_valid = 1'b1;
    frc = v.frc; fy = v.fy; ff = v.ff;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'hxxxx;
    chk({p, "_exec_mode"}, 32'({ADC, SUB, SBB, Pre_C, Src_ALU_B}), 32'(v.mode));
    chk({p, "_exec_ready"}, 32'({instr_ready, Write_En}), 32'd0);
    chk({p, "_exec_ra"}, 32'(Read_Addr_A), 32'(v.instr[8:6]));
    if (v.mode[0]) chk({p, "_exec_imm5"}, 32'(imm5), 32'(v.imm));
    @(negedge clk);
    chk({p, "_wb_we"}, 32'(Write_En), 32'd1);
    chk({p, "_wb_addr"}, 32'(Write_Addr), 32'(v.wa));
    chk({p, "_wb_data"}, 32'(Write_Data), 32'(v.wd));
    chk({p, "_wb_flags"}, 32'(flags), 32'(v.fl));
    chk({p, "_wb_mode"}, 32'({ADC, SUB, SBB, Pre_C}), 32'd0);
    @(negedge clk);
    frc = 1'b0;
    chk({p, "_idle"}, 32'({instr_ready, Write_En}), 32'b10);
    chk({p, "_rf"}, 32'(rf[v.wa]), 32'(v.wd));
    chk({p, "_we_once"}, 32'(we_count - wc0), 32'd1);
  endtask

  initial begin
    int wc;
    for (int r = 0; r < 8; r++) rf[r] = 16'h0000;
    we_count = 0;
    frc = 1'b0; fy = '0; ff = '0;
    clr = 1'b1; instr = '0; instr_valid = 1'b0;

    //            instr     frc  fy       ff       mode      imm    wa    wd        fl
    vecs[0]  = '{16'h6034, 1'b0, 16'h0, 4'b0000, 5'b00000, 5'h00, 3'd0, 16'h0034, 4'b0000};
    vecs[1]  = '{16'h6245, 1'b0, 16'h0, 4'b0000, 5'b00000, 5'h00, 3'd1, 16'h0045, 4'b0000};
    vecs[2]  = '{16'h0408, 1'b0, 16'h0, 4'b0000, 5'b00000, 5'h00, 3'd2, 16'h0079, 4'b0000};
    vecs[3]  = '{16'h5605, 1'b0, 16'h0, 4'b0000, 5'b01001, 5'h05, 3'd3, 16'h002F, 4'b0010};
    vecs[4]  = '{16'h0808, 1'b1, 16'h0, 4'b1010, 5'b00000, 5'h00, 3'd4, 16'h0000, 4'b1010};
    vecs[5]  = '{16'h1A08, 1'b0, 16'h0, 4'b0000, 5'b10010, 5'h00, 3'd5, 16'h007A, 4'b0000};
    vecs[6]  = '{16'h2C40, 1'b0, 16'h0, 4'b0000, 5'b01000, 5'h00, 3'd6, 16'h0011, 4'b0010};
    vecs[7]  = '{16'h3E08, 1'b0, 16'h0, 4'b0000, 5'b00110, 5'h00, 3'd7, 16'hFFEF, 4'b0100};
    vecs[8]  = '{16'h721F, 1'b0, 16'h0, 4'b0000, 5'b00001, 5'h00, 3'd1, 16'h0034, 4'b0100};
    vecs[9]  = '{16'h441F, 1'b0, 16'h0, 4'b0000, 5'b00001, 5'h1F, 3'd2, 16'h0053, 4'b0000};
    vecs[10] = '{16'h0808, 1'b1, 16'h0, 4'b1010, 5'b00000, 5'h00, 3'd4, 16'h0000, 4'b1010};

    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_we_ill", 32'({Write_En, illegal}), 32'd0);
    chk("rst_mode", 32'({ADC, SUB, SBB, Pre_C, Src_ALU_B}), 32'd0);
    chk("rst_bus", 32'({Read_Addr_A, Read_Addr_B, Write_Addr, imm5}), 32'd0);
    chk("rst_wdata", 32'(Write_Data), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Illegal opcode with rd=7: one-cycle pulse, no write, flags kept.
    wc = we_count;
    instr = 16'h9E00; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_ready", 32'({instr_ready, Write_En}), 32'b10);
    chk("ill_flags", 32'(flags), 32'b1010);
    @(negedge clk);
    chk("ill_drop", 32'({illegal, Write_En}), 32'd0);
    chk("ill_rf7", 32'(rf[7]), 32'hFFEF);

    // NOP: stays idle, no writes.
    instr = 16'hF000; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("nop_ready", 32'({instr_ready, illegal, Write_En}), 32'b100);
    @(negedge clk);
    chk("nop_nowrite", 32'(we_count - wc), 32'd0);
    chk("nop_flags", 32'(flags), 32'b1010);

    // Reset during EXEC of ADD r6: aborted, flags cleared.
    instr = 16'h0C08; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rexec_busy", 32'(instr_ready), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    chk("rexec_state", 32'({instr_ready, Write_En}), 32'b10);
    chk("rexec_flags", 32'(flags), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("rexec_nowrite", 32'({Write_En, 16'(we_count - wc)}), 32'd0);
    chk("rexec_rf6", 32'(rf[6]), 32'h0011);

    // Reset during WB of forced ADD r3: strobe suppressed at the reset edge.
    instr = 16'h0608; instr_valid = 1'b1;
    frc = 1'b1; fy = 16'h1234; ff = 4'b1010;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rwb_we_pre", 32'(Write_En), 32'd1);
    chk("rwb_flags_pre", 32'(flags), 32'b1010);
    clr = 1'b1;
    #1;
    chk("rwb_we_gated", 32'(Write_En), 32'd0);
    @(negedge clk);
    frc = 1'b0;
    chk("rwb_state", 32'({instr_ready, Write_En}), 32'b10);
    chk("rwb_flags", 32'(flags), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("rwb_rf3", 32'(rf[3]), 32'h002F);
    chk("rwb_nowrite", 32'(we_count - wc), 32'd0);

    // Recovery after reset: LDI r3,0x055.
    run_vec(11, '{16'h6655, 1'b0, 16'h0, 4'b0000, 5'b00000, 5'h00, 3'd3, 16'h0055, 4'b0000});

    chk("final_rf0", 32'(rf[0]), 32'h0034);
    chk("final_rf5", 32'(rf[5]), 32'h007A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
